// File: rtl/wbarbiter_dma.sv
// wbarbiter_dma
//   Two-master pipelined Wishbone arbiter with a bus watchdog. Master A is the
//   CPU and master B is the DMA controller. Both share one downstream system
//   bus. A master keeps ownership for its whole CYC. A slave that stops
//   answering is timed out: the owner receives an error, o_bus_fault pulses,
//   and the bus is released.
//
//   Ports
//     i_clk, i_rst_n              clock, asynchronous active-low reset
//     i_a_* / o_a_*               master A controls, address/data, responses
//     i_b_* / o_b_*               master B controls, address/data, responses
//     o_rdata                     shared read data, valid with o_a_ack/o_b_ack
//     o_wb_* / i_wb_*             shared slave bus
//     o_bus_fault                 one-cycle pulse when the watchdog expires
module wbarbiter_dma #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int PRIO_RR = 0,
    parameter int LGOUT   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_a_cyc,
    input  logic          i_a_stb,
    input  logic          i_a_we,
    input  logic [AW-1:0] i_a_addr,
    input  logic [DW-1:0] i_a_data,
    output logic          o_a_ack,
    output logic          o_a_stall,
    output logic          o_a_err,
    input  logic          i_b_cyc,
    input  logic          i_b_stb,
    input  logic          i_b_we,
    input  logic [AW-1:0] i_b_addr,
    input  logic [DW-1:0] i_b_data,
    output logic          o_b_ack,
    output logic          o_b_stall,
    output logic          o_b_err,
    output logic [DW-1:0] o_rdata,
    output logic          o_wb_cyc,
    output logic          o_wb_stb,
    output logic          o_wb_we,
    output logic [AW-1:0] o_wb_addr,
    output logic [DW-1:0] o_wb_data,
    input  logic          i_wb_ack,
    input  logic          i_wb_stall,
    input  logic          i_wb_err,
    input  logic [DW-1:0] i_wb_data,
    output logic          o_bus_fault
);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B, FAULT} state_t;

    localparam logic [LGOUT-1:0] MAX_OUT   = '1;
    localparam int               WD_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [9:0]       WD_LAST   = 10'(WD_LAST_I);

    state_t           state, state_nx;
    logic             last_b;       // last granted master was B; also names the faulted master
    logic [LGOUT-1:0] outstanding;
    logic [9:0]       wdog;

    logic own_a, own_b, owned;
    logic own_cyc, own_stb, own_stall;
    logic any_resp, accept, resp, wd_hit, a_wins, leaving;

    assign own_a     = (state == OWN_A);
    assign own_b     = (state == OWN_B);
    assign owned     = own_a | own_b;
    assign own_cyc   = (own_a & i_a_cyc) | (own_b & i_b_cyc);
    assign own_stb   = (own_a & i_a_stb) | (own_b & i_b_stb);
    assign own_stall = i_wb_stall | (outstanding == MAX_OUT);
    assign any_resp  = i_wb_ack | i_wb_err;
    assign accept    = o_wb_stb & ~own_stall;
    // A response with nothing in flight is stray and must not underflow the count.
    assign resp      = o_wb_cyc & any_resp & (outstanding != '0);
    // Fire on the cycle that would bring the quiet-cycle count up to TIMEOUT.
    // An owner that is already dropping CYC just leaves; no fault is raised.
    assign wd_hit    = (TIMEOUT != 0) && own_cyc && (outstanding != '0) &&
                       !any_resp && (wdog == WD_LAST);
    // Fixed priority: A always wins a tie. Round-robin: the tie goes to the
    // master that did not own the bus last.
    assign a_wins    = (PRIO_RR == 0) || !i_b_cyc || last_b;
    assign leaving   = owned && (state_nx != state);

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (i_a_cyc && a_wins) state_nx = OWN_A;
                else if (i_b_cyc)      state_nx = OWN_B;
            end
            OWN_A: begin
                if (!i_a_cyc)    state_nx = IDLE;
                else if (wd_hit) state_nx = FAULT;
            end
            OWN_B: begin
                if (!i_b_cyc)    state_nx = IDLE;
                else if (wd_hit) state_nx = FAULT;
            end
            FAULT: begin
                if (last_b ? !i_b_cyc : !i_a_cyc) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            last_b <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && state_nx == OWN_A) last_b <= 1'b0;
            if (state == IDLE && state_nx == OWN_B) last_b <= 1'b1;
        end
    end

    // Bus mux: everything comes from the owner, all zero without one.
    assign o_wb_cyc = own_cyc;
    assign o_wb_stb = own_cyc & own_stb;

    always_comb begin
        o_wb_we   = 1'b0;
        o_wb_addr = '0;
        o_wb_data = '0;
        if (own_a) begin
            o_wb_we   = i_a_we;
            o_wb_addr = i_a_addr;
            o_wb_data = i_a_data;
        end else if (own_b) begin
            o_wb_we   = i_b_we;
            o_wb_addr = i_b_addr;
            o_wb_data = i_b_data;
        end
    end

    // A non-owner is held off by echoing its own strobe. The faulted master
    // is stalled outright until it lets go of CYC.
    assign o_a_stall = own_a ? own_stall : (((state == FAULT) && !last_b) | i_a_stb);
    assign o_b_stall = own_b ? own_stall : (((state == FAULT) &&  last_b) | i_b_stb);

    // Outstanding-request counter and watchdog
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            outstanding <= '0;
            wdog        <= '0;
        end else begin
            if (!owned || leaving) begin
                outstanding <= '0;
            end else begin
                case ({accept, resp})
                    2'b10:   outstanding <= outstanding + LGOUT'(1);
                    2'b01:   outstanding <= outstanding - LGOUT'(1);
                    default: outstanding <= outstanding;
                endcase
            end

            if (!owned || leaving || any_resp || outstanding == '0)
                wdog <= '0;
            else
                wdog <= wdog + 10'd1;
        end
    end

    // Registered responses. Error beats ack when both arrive together.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_a_ack     <= 1'b0;
            o_a_err     <= 1'b0;
            o_b_ack     <= 1'b0;
            o_b_err     <= 1'b0;
            o_bus_fault <= 1'b0;
            o_rdata     <= '0;
        end else begin
            o_a_ack     <= resp & own_a & i_wb_ack & ~i_wb_err;
            o_b_ack     <= resp & own_b & i_wb_ack & ~i_wb_err;
            o_a_err     <= own_a & ((resp & i_wb_err) | wd_hit);
            o_b_err     <= own_b & ((resp & i_wb_err) | wd_hit);
            o_bus_fault <= wd_hit;
            if (i_wb_ack) o_rdata <= i_wb_data;
        end
    end

endmodule

// File: tb/tb_wbarbiter_dma.sv
// tb_wbarbiter_dma
//   Directed and randomized bench for wbarbiter_dma. The main instance uses
//   round-robin, a 2-bit outstanding counter and a 16-cycle watchdog. Every cycle
//   it is compared against a transaction-level reference model. A second
//   instance with default parameters shares the inputs and is used only to
//   check fixed-priority arbitration.
module tb_wbarbiter_dma;
    localparam int TMO     = 16;
    localparam int MAX_OUT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_cyc, a_stb, a_we, b_cyc, b_stb, b_we;
    logic [31:0] a_addr, a_data, b_addr, b_data;
    logic        wb_ack, wb_stall, wb_err;
    logic [31:0] wb_rdata;

    logic        a_ack, a_stall, a_err, b_ack, b_stall, b_err;
    logic [31:0] rdata, wb_addr, wb_data;
    logic        wb_cyc, wb_stb, wb_we, bus_fault;

    logic        z_a_ack, z_a_stall, z_a_err, z_b_ack, z_b_stall, z_b_err;
    logic [31:0] z_rdata, z_wb_addr, z_wb_data;
    logic        z_wb_cyc, z_wb_stb, z_wb_we, z_bus_fault;

    int errors = 0;
    int checks = 0;

    wbarbiter_dma #(.AW(32), .DW(32), .PRIO_RR(1), .LGOUT(2), .TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_a_cyc(a_cyc), .i_a_stb(a_stb), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_data(a_data),
        .o_a_ack(a_ack), .o_a_stall(a_stall), .o_a_err(a_err),
        .i_b_cyc(b_cyc), .i_b_stb(b_stb), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_data(b_data),
        .o_b_ack(b_ack), .o_b_stall(b_stall), .o_b_err(b_err),
        .o_rdata(rdata), .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
        .o_wb_addr(wb_addr), .o_wb_data(wb_data),
        .i_wb_ack(wb_ack), .i_wb_stall(wb_stall), .i_wb_err(wb_err), .i_wb_data(wb_rdata),
        .o_bus_fault(bus_fault)
    );

    wbarbiter_dma dut0 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_a_cyc(a_cyc), .i_a_stb(a_stb), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_data(a_data),
        .o_a_ack(z_a_ack), .o_a_stall(z_a_stall), .o_a_err(z_a_err),
        .i_b_cyc(b_cyc), .i_b_stb(b_stb), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_data(b_data),
        .o_b_ack(z_b_ack), .o_b_stall(z_b_stall), .o_b_err(z_b_err),
        .o_rdata(z_rdata), .o_wb_cyc(z_wb_cyc), .o_wb_stb(z_wb_stb), .o_wb_we(z_wb_we),
        .o_wb_addr(z_wb_addr), .o_wb_data(z_wb_data),
        .i_wb_ack(wb_ack), .i_wb_stall(wb_stall), .i_wb_err(wb_err), .i_wb_data(wb_rdata),
        .o_bus_fault(z_bus_fault)
    );

    // Reference model: who owns the bus (0 none, 1 A, 2 B), who is faulted,
    // requests in flight, quiet cycles while waiting, and the last grantee.
    int          m_own, m_flt, m_cnt, m_quiet, m_last;
    logic        m_ack_a, m_ack_b, m_err_a, m_err_b, m_fault;
    logic [31:0] m_rdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_own = 0; m_flt = 0; m_cnt = 0; m_quiet = 0; m_last = 1;
        m_ack_a = 0; m_ack_b = 0; m_err_a = 0; m_err_b = 0; m_fault = 0;
        m_rdata = '0;
    endtask

    task automatic check_outputs();
        logic        ocyc, ostb, owe, ostall;
        logic [31:0] oaddr, odata;
        ocyc = 0; ostb = 0; owe = 0; oaddr = '0; odata = '0;
        if (m_own == 1) begin ocyc = a_cyc; ostb = a_stb; owe = a_we; oaddr = a_addr; odata = a_data; end
        if (m_own == 2) begin ocyc = b_cyc; ostb = b_stb; owe = b_we; oaddr = b_addr; odata = b_data; end
        ostall = wb_stall || (m_cnt == MAX_OUT);
        chk("wb_cyc", {31'd0, wb_cyc}, {31'd0, ocyc});
        chk("wb_stb", {31'd0, wb_stb}, {31'd0, ocyc & ostb});
        chk("wb_we", {31'd0, wb_we}, {31'd0, owe});
        chk("wb_addr", wb_addr, oaddr);
        chk("wb_data", wb_data, odata);
        chk("a_stall", {31'd0, a_stall}, {31'd0, (m_own == 1) ? ostall : ((m_flt == 1) | a_stb)});
        chk("b_stall", {31'd0, b_stall}, {31'd0, (m_own == 2) ? ostall : ((m_flt == 2) | b_stb)});
        chk("a_ack", {31'd0, a_ack}, {31'd0, m_ack_a});
        chk("b_ack", {31'd0, b_ack}, {31'd0, m_ack_b});
        chk("a_err", {31'd0, a_err}, {31'd0, m_err_a});
        chk("b_err", {31'd0, b_err}, {31'd0, m_err_b});
        chk("bus_fault", {31'd0, bus_fault}, {31'd0, m_fault});
        chk("rdata", rdata, m_rdata);
    endtask

    task automatic model_step();
        logic ocyc, ostb, ostall, acc, rsp, expire, anyr;
        if (!rst_n) begin
            model_reset();
            return;
        end
        ocyc   = (m_own == 1) ? a_cyc : (m_own == 2) ? b_cyc : 1'b0;
        ostb   = (m_own == 1) ? a_stb : (m_own == 2) ? b_stb : 1'b0;
        anyr   = wb_ack | wb_err;
        ostall = wb_stall || (m_cnt == MAX_OUT);
        acc    = ocyc && ostb && !ostall;
        rsp    = ocyc && anyr && (m_cnt > 0);
        expire = ocyc && (m_cnt > 0) && !anyr && (m_quiet == TMO - 1);
        m_ack_a = rsp && wb_ack && !wb_err && (m_own == 1);
        m_ack_b = rsp && wb_ack && !wb_err && (m_own == 2);
        m_err_a = (m_own == 1) && ((rsp && wb_err) || expire);
        m_err_b = (m_own == 2) && ((rsp && wb_err) || expire);
        m_fault = expire;
        if (wb_ack) m_rdata = wb_rdata;
        m_quiet = (m_own == 0 || m_cnt == 0 || anyr) ? 0 : m_quiet + 1;
        if (m_own != 0) begin
            if (!ocyc) begin
                m_own = 0; m_cnt = 0; m_quiet = 0;
            end else if (expire) begin
                m_flt = m_own; m_own = 0; m_cnt = 0; m_quiet = 0;
            end else begin
                m_cnt = m_cnt + int'(acc) - int'(rsp);
            end
        end else if (m_flt != 0) begin
            if (!((m_flt == 1) ? a_cyc : b_cyc)) m_flt = 0;
        end else begin
            if (a_cyc && (!b_cyc || m_last == 2)) begin m_own = 1; m_last = 1; end
            else if (b_cyc)                       begin m_own = 2; m_last = 2; end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, sent, acked, pend;
        logic hs;
        model_reset();
        a_cyc = 0; a_stb = 0; a_we = 0; a_addr = '0; a_data = '0;
        b_cyc = 0; b_stb = 0; b_we = 0; b_addr = '0; b_data = '0;
        wb_ack = 0; wb_stall = 0; wb_err = 0; wb_rdata = '0;

        // reset state
        #1;
        chk("rst_wb_cyc", {31'd0, wb_cyc}, 32'd0);
        chk("rst_fault", {31'd0, bus_fault}, 32'd0);
        a_stb = 1; #1;
        chk("rst_a_stall_echo", {31'd0, a_stall}, 32'd1);
        a_stb = 0;
        cycle(); cycle();
        rst_n = 1;
        cycle();

        // single read by A
        a_cyc = 1; a_stb = 1; a_addr = 32'h100; a_we = 0;
        cycle();
        cycle();
        a_stb = 0;
        cycle();
        wb_ack = 1; wb_rdata = 32'hDEADBEEF;
        cycle();
        wb_ack = 0; wb_rdata = $urandom;
        #1;
        chk("s1_a_ack", {31'd0, a_ack}, 32'd1);
        chk("s1_rdata", rdata, 32'hDEADBEEF);
        chk("s1_b_ack", {31'd0, b_ack}, 32'd0);
        a_cyc = 0;
        cycle(); cycle();

        // simultaneous request: fixed priority vs round-robin
        a_cyc = 1; b_cyc = 1; a_stb = 0; b_stb = 1;
        a_addr = 32'hA000_0000; b_addr = 32'hB000_0000;
        #1;
        chk("s2_z_idle_cyc", {31'd0, z_wb_cyc}, 32'd0);
        chk("s2_z_idle_bstall", {31'd0, z_b_stall}, 32'd1);
        cycle();
        #1;
        chk("s2_z_grant_a", z_wb_addr, 32'hA000_0000);
        chk("s2_z_b_stall1", {31'd0, z_b_stall}, 32'd1);
        chk("s2_rr_grant_b", wb_addr, 32'hB000_0000);
        cycle();
        #1;
        chk("s2_z_b_stall2", {31'd0, z_b_stall}, 32'd1);
        cycle();
        a_cyc = 0;
        #1;
        chk("s2_z_drop_cyc", {31'd0, z_wb_cyc}, 32'd0);
        chk("s2_z_b_stall3", {31'd0, z_b_stall}, 32'd1);
        cycle();
        #1;
        chk("s2_z_idle_gap", {31'd0, z_wb_cyc}, 32'd0);
        chk("s2_z_b_stall4", {31'd0, z_b_stall}, 32'd1);
        cycle();
        #1;
        chk("s2_z_grant_b", z_wb_addr, 32'hB000_0000);
        chk("s2_z_b_go", {31'd0, z_b_stall}, 32'd0);
        cycle();
        b_cyc = 0; b_stb = 0;
        cycle(); cycle();
        a_cyc = 1; b_cyc = 1;
        cycle();
        #1;
        chk("s2_rr_repeat_a", wb_addr, 32'hA000_0000);
        a_cyc = 0; b_cyc = 0;
        cycle(); cycle();

        // DMA burst of 8 writes with a jittery slave
        b_cyc = 1; b_we = 1; sent = 0; acked = 0; pend = 0;
        for (int k = 0; k < 300 && acked < 8; k++) begin
            b_stb    = (sent < 8);
            b_addr   = 32'h2000 + 32'(sent * 4);
            b_data   = $urandom;
            wb_stall = ($urandom_range(0, 1) == 1);
            wb_ack   = (pend > 0) && ($urandom_range(0, 3) != 0);
            wb_rdata = $urandom;
            #1;
            hs = wb_stb && !b_stall;
            cycle();
            if (hs) begin sent++; pend++; end
            if (wb_ack) pend--;
            if (b_ack) acked++;
        end
        b_stb = 0; wb_ack = 0; wb_stall = 0;
        cycle();
        if (b_ack) acked++;
        chk("s3_handshakes", 32'(sent), 32'd8);
        chk("s3_acks", 32'(acked), 32'd8);
        b_cyc = 0;
        cycle(); cycle();

        // watchdog: B read that is never answered
        b_cyc = 1; b_stb = 1; b_we = 0; b_addr = 32'h3000;
        cycle();
        cycle();
        b_stb = 0;
        n = 0;
        while (b_err !== 1'b1 && n < 40) begin
            cycle();
            n++;
        end
        chk("s4_delay", 32'(n), 32'd16);
        chk("s4_fault_pulse", {31'd0, bus_fault}, 32'd1);
        chk("s4_cyc_dropped", {31'd0, wb_cyc}, 32'd0);
        chk("s4_a_err_quiet", {31'd0, a_err}, 32'd0);
        wb_ack = 1; wb_rdata = 32'h1234_5678;
        cycle();
        wb_ack = 0;
        #1;
        chk("s4_late_ack", {31'd0, b_ack}, 32'd0);
        chk("s4_pulse_end", {31'd0, bus_fault}, 32'd0);
        chk("s4_faulted_stall", {31'd0, b_stall}, 32'd1);
        b_cyc = 0;
        cycle();
        #1;
        chk("s4_released", {31'd0, b_stall}, 32'd0);
        cycle();

        // outstanding limit and err+ack collision
        a_cyc = 1; a_stb = 1; a_we = 1; a_addr = 32'h4000;
        cycle();
        cycle(); cycle(); cycle();
        #1;
        chk("s5_full_stall", {31'd0, a_stall}, 32'd1);
        cycle();
        wb_ack = 1; wb_err = 1;
        cycle();
        wb_ack = 0; wb_err = 0;
        #1;
        chk("s5_err_only", {31'd0, a_err}, 32'd1);
        chk("s5_no_ack", {31'd0, a_ack}, 32'd0);
        chk("s5_count_dec", {31'd0, a_stall}, 32'd0);
        a_stb = 0;
        cycle();
        a_cyc = 0;
        cycle(); cycle();

        // random traffic from both masters
        for (int k = 0; k < 120; k++) begin
            if ($urandom_range(0, 5) == 0) a_cyc = ~a_cyc;
            if ($urandom_range(0, 5) == 0) b_cyc = ~b_cyc;
            a_stb    = a_cyc && ($urandom_range(0, 1) == 1);
            b_stb    = b_cyc && ($urandom_range(0, 1) == 1);
            a_we     = ($urandom_range(0, 1) == 1);
            b_we     = ($urandom_range(0, 1) == 1);
            a_addr   = $urandom; a_data = $urandom;
            b_addr   = $urandom; b_data = $urandom;
            wb_stall = ($urandom_range(0, 3) == 0);
            wb_ack   = ($urandom_range(0, 3) == 0);
            wb_err   = ($urandom_range(0, 11) == 0);
            wb_rdata = $urandom;
            cycle();
        end
        a_cyc = 0; b_cyc = 0; a_stb = 0; b_stb = 0;
        wb_ack = 0; wb_err = 0; wb_stall = 0;
        cycle(); cycle(); cycle();

        // reset in the middle of a B burst
        b_cyc = 1; b_stb = 1; b_we = 1; b_addr = 32'h5000; a_addr = 32'h6000;
        cycle(); cycle(); cycle();
        rst_n = 0;
        #1;
        model_reset();
        chk("s6_cyc_async", {31'd0, wb_cyc}, 32'd0);
        chk("s6_stb_async", {31'd0, wb_stb}, 32'd0);
        chk("s6_b_stall_echo", {31'd0, b_stall}, 32'd1);
        cycle(); cycle();
        a_cyc = 1; rst_n = 1;
        cycle();
        #1;
        chk("s6_fresh_grant", wb_addr, 32'h5000);
        cycle();
        a_cyc = 0; b_cyc = 0; b_stb = 0;
        cycle(); cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
